// File: rtl/multicycle_control.sv
// Multicycle MIPS-1 control FSM: Moore outputs, 3-5 cycles per instruction (beq/j 3, lw 5).
// Memory states stall on mem_ready_i unless MEM_WAIT=0; illegal opcodes park in TRAP until reset.
module multicycle_control #(
    parameter int unsigned ENABLE_ADDI = 1,
    parameter int unsigned ENABLE_JUMP = 1,
    parameter int unsigned MEM_WAIT    = 1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [5:0] Op_i,
    input  logic       mem_ready_i,
    output logic       mem_req_o,
    output logic       IorD_o,
    output logic       MemWrite_o,
    output logic       IRWrite_o,
    output logic       RegDst_o,
    output logic       MemtoReg_o,
    output logic       RegWrite_o,
    output logic       AluSrcA_o,
    output logic [1:0] AluSrcB_o,
    output logic [1:0] AluOp_o,
    output logic [1:0] PCSrc_o,
    output logic       PCWrite_o,
    output logic       Branch_o,
    output logic       instr_done_o,
    output logic       illegal_o,
    output logic [3:0] state_o
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11,
        S_TRAP     = 4'd12
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_e state_q, state_d;
    logic   rdy;

    // With MEM_WAIT=0 the memory is assumed single-cycle and the handshake is ignored.
    assign rdy = mem_ready_i | (MEM_WAIT == 0);

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:    state_d = rdy ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (Op_i)
                    OP_RTYPE:      state_d = S_EXECUTE;
                    OP_LW, OP_SW:  state_d = S_MEMADR;
                    OP_BEQ:        state_d = S_BRANCH;
                    OP_ADDI:       state_d = (ENABLE_ADDI != 0) ? S_ADDIEXEC : S_TRAP;
                    OP_J:          state_d = (ENABLE_JUMP != 0) ? S_JUMP : S_TRAP;
                    default:       state_d = S_TRAP;
                endcase
            end
            S_MEMADR:   state_d = (Op_i == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = rdy ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = rdy ? S_FETCH : S_MEMWRITE;
            S_EXECUTE:  state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_ADDIEXEC: state_d = S_ADDIWB;
            S_ADDIWB:   state_d = S_FETCH;
            S_JUMP:     state_d = S_FETCH;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_FETCH;
        endcase
    end

    always_comb begin
        mem_req_o    = 1'b0;
        IorD_o       = 1'b0;
        MemWrite_o   = 1'b0;
        IRWrite_o    = 1'b0;
        RegDst_o     = 1'b0;
        MemtoReg_o   = 1'b0;
        RegWrite_o   = 1'b0;
        AluSrcA_o    = 1'b0;
        AluSrcB_o    = 2'b00;
        AluOp_o      = 2'b00;
        PCSrc_o      = 2'b00;
        PCWrite_o    = 1'b0;
        Branch_o     = 1'b0;
        instr_done_o = 1'b0;
        illegal_o    = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req_o = 1'b1;
                AluSrcB_o = 2'b01;
                IRWrite_o = rdy;
                PCWrite_o = rdy;
            end
            S_DECODE:   AluSrcB_o = 2'b11;
            S_MEMADR: begin
                AluSrcA_o = 1'b1;
                AluSrcB_o = 2'b10;
            end
            S_MEMREAD: begin
                mem_req_o = 1'b1;
                IorD_o    = 1'b1;
            end
            S_MEMWB: begin
                MemtoReg_o   = 1'b1;
                RegWrite_o   = 1'b1;
                instr_done_o = 1'b1;
            end
            S_MEMWRITE: begin
                mem_req_o    = 1'b1;
                IorD_o       = 1'b1;
                MemWrite_o   = 1'b1;
                instr_done_o = rdy;
            end
            S_EXECUTE: begin
                AluSrcA_o = 1'b1;
                AluOp_o   = 2'b10;
            end
            S_ALUWB: begin
                RegDst_o     = 1'b1;
                RegWrite_o   = 1'b1;
                instr_done_o = 1'b1;
            end
            S_BRANCH: begin
                AluSrcA_o    = 1'b1;
                AluOp_o      = 2'b01;
                PCSrc_o      = 2'b01;
                Branch_o     = 1'b1;
                instr_done_o = 1'b1;
            end
            S_ADDIEXEC: begin
                AluSrcA_o = 1'b1;
                AluSrcB_o = 2'b10;
            end
            S_ADDIWB: begin
                RegWrite_o   = 1'b1;
                instr_done_o = 1'b1;
            end
            S_JUMP: begin
                PCSrc_o      = 2'b10;
                PCWrite_o    = 1'b1;
                instr_done_o = 1'b1;
            end
            S_TRAP: begin
                illegal_o = 1'b1;
                AluOp_o   = 2'b11;
            end
            default: ;
        endcase
    end

    assign state_o = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: default, no-jump and no-wait instances driven from shared stimulus.
module tb_multicycle_control;

    localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011;
    localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, J = 6'b000010;

    logic       clk_i = 1'b0;
    logic       rst_i, mem_ready_i;
    logic [5:0] op_i;

    always #5 clk_i = ~clk_i;

    logic       mreq_a, iord_a, mw_a, irw_a, rd_a, m2r_a, rw_a, sa_a, pw_a, br_a, dn_a, il_a;
    logic       mreq_j, iord_j, mw_j, irw_j, rd_j, m2r_j, rw_j, sa_j, pw_j, br_j, dn_j, il_j;
    logic       mreq_w, iord_w, mw_w, irw_w, rd_w, m2r_w, rw_w, sa_w, pw_w, br_w, dn_w, il_w;
    logic [1:0] sb_a, ao_a, ps_a, sb_j, ao_j, ps_j, sb_w, ao_w, ps_w;
    logic [3:0] st_a, st_j, st_w;

    multicycle_control u_dut_a (
        .clk_i(clk_i), .rst_i(rst_i), .Op_i(op_i), .mem_ready_i(mem_ready_i),
        .mem_req_o(mreq_a), .IorD_o(iord_a), .MemWrite_o(mw_a), .IRWrite_o(irw_a),
        .RegDst_o(rd_a), .MemtoReg_o(m2r_a), .RegWrite_o(rw_a), .AluSrcA_o(sa_a),
        .AluSrcB_o(sb_a), .AluOp_o(ao_a), .PCSrc_o(ps_a), .PCWrite_o(pw_a),
        .Branch_o(br_a), .instr_done_o(dn_a), .illegal_o(il_a), .state_o(st_a)
    );

    multicycle_control #(.ENABLE_ADDI(1), .ENABLE_JUMP(0), .MEM_WAIT(1)) u_dut_j (
        .clk_i(clk_i), .rst_i(rst_i), .Op_i(op_i), .mem_ready_i(mem_ready_i),
        .mem_req_o(mreq_j), .IorD_o(iord_j), .MemWrite_o(mw_j), .IRWrite_o(irw_j),
        .RegDst_o(rd_j), .MemtoReg_o(m2r_j), .RegWrite_o(rw_j), .AluSrcA_o(sa_j),
        .AluSrcB_o(sb_j), .AluOp_o(ao_j), .PCSrc_o(ps_j), .PCWrite_o(pw_j),
        .Branch_o(br_j), .instr_done_o(dn_j), .illegal_o(il_j), .state_o(st_j)
    );

    multicycle_control #(.ENABLE_ADDI(1), .ENABLE_JUMP(1), .MEM_WAIT(0)) u_dut_w (
        .clk_i(clk_i), .rst_i(rst_i), .Op_i(op_i), .mem_ready_i(mem_ready_i),
        .mem_req_o(mreq_w), .IorD_o(iord_w), .MemWrite_o(mw_w), .IRWrite_o(irw_w),
        .RegDst_o(rd_w), .MemtoReg_o(m2r_w), .RegWrite_o(rw_w), .AluSrcA_o(sa_w),
        .AluSrcB_o(sb_w), .AluOp_o(ao_w), .PCSrc_o(ps_w), .PCWrite_o(pw_w),
        .Branch_o(br_w), .instr_done_o(dn_w), .illegal_o(il_w), .state_o(st_w)
    );

    // Observation vector layout, MSB first:
    // state, mem_req, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, AluSrcA,
    // AluSrcB, AluOp, PCSrc, PCWrite, Branch, instr_done (bit 1), illegal (bit 0).
    // RegWrite is bit 11, MemWrite bit 15.
    logic [21:0] obs_a, obs_j, obs_w;
    assign obs_a = {st_a, mreq_a, iord_a, mw_a, irw_a, rd_a, m2r_a, rw_a, sa_a, sb_a, ao_a, ps_a, pw_a, br_a, dn_a, il_a};
    assign obs_j = {st_j, mreq_j, iord_j, mw_j, irw_j, rd_j, m2r_j, rw_j, sa_j, sb_j, ao_j, ps_j, pw_j, br_j, dn_j, il_j};
    assign obs_w = {st_w, mreq_w, iord_w, mw_w, irw_w, rd_w, m2r_w, rw_w, sa_w, sb_w, ao_w, ps_w, pw_w, br_w, dn_w, il_w};

    // Reference output table per state; g is the effective memory-ready for gated outputs.
    function automatic logic [21:0] spec_vec(input logic [3:0] st, input logic g);
        logic mr, io, mw, irw, rd, m2r, rw, sa, pw, br, dn, il;
        logic [1:0] sb, ao, ps;
        {mr, io, mw, irw, rd, m2r, rw, sa, pw, br, dn, il} = '0;
        sb = 2'b00; ao = 2'b00; ps = 2'b00;
        case (st)
            4'd0:  begin mr = 1'b1; irw = g; pw = g; sb = 2'b01; end
            4'd1:  sb = 2'b11;
            4'd2:  begin sa = 1'b1; sb = 2'b10; end
            4'd3:  begin mr = 1'b1; io = 1'b1; end
            4'd4:  begin m2r = 1'b1; rw = 1'b1; dn = 1'b1; end
            4'd5:  begin mr = 1'b1; io = 1'b1; mw = 1'b1; dn = g; end
            4'd6:  begin sa = 1'b1; ao = 2'b10; end
            4'd7:  begin rd = 1'b1; rw = 1'b1; dn = 1'b1; end
            4'd8:  begin sa = 1'b1; ao = 2'b01; ps = 2'b01; br = 1'b1; dn = 1'b1; end
            4'd9:  begin sa = 1'b1; sb = 2'b10; end
            4'd10: begin rw = 1'b1; dn = 1'b1; end
            4'd11: begin ps = 2'b10; pw = 1'b1; dn = 1'b1; end
            4'd12: begin il = 1'b1; ao = 2'b11; end
            default: ;
        endcase
        return {st, mr, io, mw, irw, rd, m2r, rw, sa, sb, ao, ps, pw, br, dn, il};
    endfunction

    function automatic logic [21:0] pick(input int d);
        return (d == 0) ? obs_a : (d == 1) ? obs_j : obs_w;
    endfunction

    // Scoreboard entry: stimulus for one cycle plus the state the DUT must be in during it.
    typedef struct {
        int         dut;
        logic       rst;
        logic       rdy;
        logic [5:0] op;
        logic [3:0] st;
    } ent_t;

    ent_t        sbq[$];
    int          total = 0;
    int          bad   = 0;
    int          dones, cyc, done_cyc, rw_hits;
    ent_t        e;
    logic [21:0] ob, ex;

    task automatic push(input int d, input logic r, input logic y, input logic [5:0] o, input logic [3:0] s);
        ent_t t;
        t.dut = d; t.rst = r; t.rdy = y; t.op = o; t.st = s;
        sbq.push_back(t);
    endtask

    task automatic test_reset();
        rst_i = 1'b1; mem_ready_i = 1'b1; op_i = R;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        total++; if (st_a !== 4'd0) begin bad++; $display("FAIL reset_state_a got=%0d exp=0", st_a); end
        total++; if (st_j !== 4'd0) begin bad++; $display("FAIL reset_state_j got=%0d exp=0", st_j); end
        total++; if (st_w !== 4'd0) begin bad++; $display("FAIL reset_state_w got=%0d exp=0", st_w); end
        total++; if (obs_a !== spec_vec(4'd0, 1'b1)) begin
            bad++; $display("FAIL reset_outputs got=%h exp=%h", obs_a, spec_vec(4'd0, 1'b1));
        end
    endtask

    task automatic test_rtype();
        push(0, 0, 1, R, 0); push(0, 0, 1, R, 1); push(0, 0, 1, R, 6); push(0, 0, 1, R, 7);
        dones = 0; cyc = 0;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            rst_i = e.rst; mem_ready_i = e.rdy; op_i = e.op;
            #1;
            ob = pick(e.dut); ex = spec_vec(e.st, (e.dut == 2) ? 1'b1 : e.rdy);
            total++; if (ob !== ex) begin bad++; $display("FAIL rtype cyc=%0d got=%h exp=%h", cyc, ob, ex); end
            if (ob[1]) dones++;
            cyc++;
            @(negedge clk_i);
        end
        total++; if (dones !== 1) begin bad++; $display("FAIL rtype_done_count got=%0d exp=1", dones); end
        total++; if (st_a !== 4'd0) begin bad++; $display("FAIL rtype_back_to_fetch got=%0d exp=0", st_a); end
    endtask

    task automatic test_lw_stall();
        push(0, 0, 0, LW, 0); push(0, 0, 0, LW, 0); push(0, 0, 1, LW, 0); push(0, 0, 1, LW, 1);
        push(0, 0, 1, LW, 2); push(0, 0, 0, LW, 3); push(0, 0, 1, LW, 3); push(0, 0, 1, LW, 4);
        dones = 0; cyc = 0; done_cyc = -1;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            rst_i = e.rst; mem_ready_i = e.rdy; op_i = e.op;
            #1;
            ob = pick(e.dut); ex = spec_vec(e.st, (e.dut == 2) ? 1'b1 : e.rdy);
            total++; if (ob !== ex) begin bad++; $display("FAIL lw_stall cyc=%0d got=%h exp=%h", cyc, ob, ex); end
            if (ob[1]) begin dones++; done_cyc = cyc; end
            cyc++;
            @(negedge clk_i);
        end
        total++; if (dones !== 1) begin bad++; $display("FAIL lw_done_count got=%0d exp=1", dones); end
        total++; if (done_cyc !== 7) begin bad++; $display("FAIL lw_latency got=%0d exp=8", done_cyc + 1); end
    endtask

    task automatic test_sw_beq();
        push(0, 0, 1, SW, 0); push(0, 0, 1, SW, 1); push(0, 0, 1, SW, 2); push(0, 0, 1, SW, 5);
        push(0, 0, 1, BEQ, 0); push(0, 0, 1, BEQ, 1); push(0, 0, 1, BEQ, 8);
        dones = 0; cyc = 0; rw_hits = 0;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            rst_i = e.rst; mem_ready_i = e.rdy; op_i = e.op;
            #1;
            ob = pick(e.dut); ex = spec_vec(e.st, (e.dut == 2) ? 1'b1 : e.rdy);
            total++; if (ob !== ex) begin bad++; $display("FAIL sw_beq cyc=%0d got=%h exp=%h", cyc, ob, ex); end
            if (ob[1]) dones++;
            if (ob[11]) rw_hits++;
            cyc++;
            @(negedge clk_i);
        end
        total++; if (dones !== 2) begin bad++; $display("FAIL sw_beq_done_count got=%0d exp=2", dones); end
        total++; if (rw_hits !== 0) begin bad++; $display("FAIL sw_beq_regwrite got=%0d exp=0", rw_hits); end
    endtask

    task automatic test_jump();
        push(0, 0, 1, J, 0); push(0, 0, 1, J, 1); push(0, 0, 1, J, 11); push(0, 0, 1, R, 0);
        dones = 0; cyc = 0;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            rst_i = e.rst; mem_ready_i = e.rdy; op_i = e.op;
            #1;
            ob = pick(e.dut); ex = spec_vec(e.st, (e.dut == 2) ? 1'b1 : e.rdy);
            total++; if (ob !== ex) begin bad++; $display("FAIL jump cyc=%0d got=%h exp=%h", cyc, ob, ex); end
            if (ob[1]) dones++;
            cyc++;
            @(negedge clk_i);
        end
        total++; if (dones !== 1) begin bad++; $display("FAIL jump_done_count got=%0d exp=1", dones); end
    endtask

    task automatic test_param_trap_addi();
        rst_i = 1'b1;
        @(negedge clk_i);
        push(1, 0, 1, J, 0); push(1, 0, 1, J, 1);
        for (int i = 0; i < 10; i++) push(1, 0, 1, J, 12);
        push(1, 1, 1, ADDI, 12);
        push(1, 0, 1, ADDI, 0); push(1, 0, 1, ADDI, 1); push(1, 0, 1, ADDI, 9); push(1, 0, 1, ADDI, 10);
        dones = 0; cyc = 0;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            rst_i = e.rst; mem_ready_i = e.rdy; op_i = e.op;
            #1;
            ob = pick(e.dut); ex = spec_vec(e.st, (e.dut == 2) ? 1'b1 : e.rdy);
            total++; if (ob !== ex) begin bad++; $display("FAIL trap_addi cyc=%0d got=%h exp=%h", cyc, ob, ex); end
            if (ob[1]) dones++;
            cyc++;
            @(negedge clk_i);
        end
        total++; if (dones !== 1) begin bad++; $display("FAIL trap_addi_done_count got=%0d exp=1", dones); end
    endtask

    task automatic test_reset_mid();
        rst_i = 1'b1;
        @(negedge clk_i);
        push(0, 0, 1, LW, 0); push(0, 0, 1, LW, 1); push(0, 0, 1, LW, 2); push(0, 0, 0, LW, 3);
        push(0, 1, 0, LW, 3); push(0, 0, 0, LW, 0); push(0, 0, 1, LW, 0);
        dones = 0; cyc = 0;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            rst_i = e.rst; mem_ready_i = e.rdy; op_i = e.op;
            #1;
            ob = pick(e.dut); ex = spec_vec(e.st, (e.dut == 2) ? 1'b1 : e.rdy);
            total++; if (ob !== ex) begin bad++; $display("FAIL reset_mid cyc=%0d got=%h exp=%h", cyc, ob, ex); end
            if (ob[1]) dones++;
            cyc++;
            @(negedge clk_i);
        end
        total++; if (dones !== 0) begin bad++; $display("FAIL reset_mid_done_count got=%0d exp=0", dones); end
    endtask

    task automatic test_memwait0();
        rst_i = 1'b1;
        @(negedge clk_i);
        push(2, 0, 0, LW, 0); push(2, 0, 0, LW, 1); push(2, 0, 0, LW, 2);
        push(2, 0, 0, LW, 3); push(2, 0, 0, LW, 4); push(2, 0, 0, LW, 0);
        dones = 0; cyc = 0; done_cyc = -1;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            rst_i = e.rst; mem_ready_i = e.rdy; op_i = e.op;
            #1;
            ob = pick(e.dut); ex = spec_vec(e.st, (e.dut == 2) ? 1'b1 : e.rdy);
            total++; if (ob !== ex) begin bad++; $display("FAIL memwait0 cyc=%0d got=%h exp=%h", cyc, ob, ex); end
            if (ob[1]) begin dones++; done_cyc = cyc; end
            cyc++;
            @(negedge clk_i);
        end
        total++; if (dones !== 1) begin bad++; $display("FAIL memwait0_done_count got=%0d exp=1", dones); end
        total++; if (done_cyc !== 4) begin bad++; $display("FAIL memwait0_latency got=%0d exp=5", done_cyc + 1); end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw_stall();
        test_sw_beq();
        test_jump();
        test_param_trap_addi();
        test_reset_mid();
        test_memwait0();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
